uart_receive: RTL and testbench
===============================

# uart_receive

Serial-to-parallel UART receiver for 8N1 framing. It sits directly downstream of the simulation transactor's transmitter, consuming its serial line, and sits upstream of any byte consumer through a valid/ready handshake. Each bit is sampled at its mid-point by a per-bit baud counter. Completed bytes are held in a one-entry output register, and stop-bit and overrun errors are flagged.

## Interface
- CLOCK_FREQUENCY, 125_000_000: clock rate in Hz.
- BAUD_RATE, 115_200: line rate in baud. N_CLOCKS = CLOCK_FREQUENCY / BAUD_RATE (integer division) must be ≥ 4.
- i_clock  input  1  sole clock; all logic on its rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_rx  input  1  serial line; idles high.
- o_data  output  8  received byte; valid while o_data_valid is high.
- o_data_valid  output  1  a byte is held in the output register.
- i_data_ready  input  1  consumer accepts the byte in any cycle where it and o_data_valid are both high.
- o_framing_error  output  1  one-cycle pulse: the stop bit was sampled low.
- o_overrun  output  1  one-cycle pulse: a byte completed while the output register was full and not being drained.

## Operation
- The internal sample point rx_s is i_rx directly, or the synchronized i_rx (see Configuration).
- HALF = N_CLOCKS / 2. Counter width N_WIDTH = $clog2(N_CLOCKS). The counter resets to 0 on every state change and after every sample.
- **IDLE**: when rx_s == 0, go to START with counter = 0.
- **START**:
  - At counter == HALF-1, sample rx_s.
  - If the sample is 1, it is a false start: return to IDLE. No flag is raised.
  - If the sample is 0, go to DATA with bit index = 0.
- **DATA**:
  - At counter == N_CLOCKS-1, shift rx_s in LSB first: shift <= {rx_s, shift[7:1]}.
  - After the 8th bit, go to STOP.
- **STOP**:
  - At counter == N_CLOCKS-1, sample rx_s.
  - If 1: the byte completes.
  - If 0: pulse o_framing_error and discard the byte.
  - In both cases go to IDLE in the same cycle. The receiver rearms mid-stop-bit, so back-to-back frames are caught.
- **Output register** (one entry):
  - On byte completion, if !o_data_valid, or if o_data_valid && i_data_ready: load o_data and set o_data_valid.
  - If o_data_valid && !i_data_ready at completion: pulse o_overrun, drop the new byte, keep the old one.
  - When the handshake fires with no completion in the same cycle, o_data_valid clears. o_data holds its last value.
- A framing error never affects o_data or o_data_valid.

## Timing
- Reset values:
  - state = IDLE, counter = 0, shift = 0.
  - o_data = 8'h00, o_data_valid = 0, o_framing_error = 0, o_overrun = 0.
- Reset mid-frame abandons the frame. The receiver re-arms on the next low rx_s after reset deasserts.
- Let E0 be the edge where IDLE sees rx_s == 0.
  - Start bit sampled at E0 + HALF.
  - Data bit k (0..7) sampled at E0 + HALF + (k+1)·N_CLOCKS.
  - Stop bit sampled at E0 + HALF + 9·N_CLOCKS.
  - o_data_valid is high the cycle after the stop-bit sample edge.
- The synchronizer adds exactly 2 cycles between i_rx and rx_s.
- o_data_valid does not depend combinationally on i_data_ready.
- Completion and handshake in the same cycle: o_data_valid stays 1, o_data takes the new byte, and o_overrun stays 0.

## Configuration
- UART_RECEIVE_SYNCHRONIZER_EN:
  - Defined: i_rx passes through a 2-flop synchronizer, reset to 1, before reaching rx_s. All latencies gain 2 cycles.
  - Undefined: rx_s = i_rx. This mode is only for synchronous simulation against the transmitter.

## Structure
- Shared package uart_pkg holds:
  - the receive state enum (IDLE, START, DATA, STOP);
  - the frame constants: 8 data bits, 1 stop bit.
- Sub-module uart_synchronizer: a parameterizable-depth flop chain with a reset value. It is instantiated only under UART_RECEIVE_SYNCHRONIZER_EN.

## Test plan
All scenarios use CLOCK_FREQUENCY = 1_600_000 and BAUD_RATE = 100_000 (N_CLOCKS = 16), with the macro undefined unless stated.
- Loopback from the transmitter, sending 8'hA5 with ready held high: o_data = 8'hA5, valid for one cycle, 152 cycles after E0.
- Bytes 8'h00, 8'hFF, 8'h3C sent back to back with no idle gap: all three received in order, no error pulses.
- Frame 8'h55 with the stop bit driven low: o_framing_error pulses once, o_data_valid stays 0, and the next frame 8'h12 is received correctly.
- A 4-cycle low glitch on an idle line: no valid, no flags, state back in IDLE.
- Ready held low while sending 8'h11 then 8'h22: o_data stays 8'h11, o_overrun pulses at the second completion. Raising ready then drains 8'h11 only.
- Reset asserted mid-DATA, then a clean 8'h7E: 8'h7E is received. With the macro defined, the same byte is received 154 cycles after the falling edge of i_rx.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive state encoding and 8N1 frame constants.
package uart_pkg;

    // Receiver phases: waiting for a start edge, qualifying the start bit,
    // collecting data bits, and checking the stop bit.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_t;

    // 8N1 framing: eight data bits, no parity, one stop bit.
    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Clocks per bit period for a given clock frequency and line rate.
    function automatic int clocks_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/uart_synchronizer.sv
// Flop chain for bringing an asynchronous single-bit signal into the i_clock
// domain. DEPTH stages, each reset to RESET_VALUE. DEPTH must be at least 2.
module uart_synchronizer #(
    parameter int   DEPTH       = 2,
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_data,
    output logic o_data
);

    logic [DEPTH-1:0] chain_q;

    // Shift the input through the chain; reset preloads the idle level.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            chain_q <= {DEPTH{RESET_VALUE}};
        end else begin
            chain_q <= {chain_q[DEPTH-2:0], i_data};
        end
    end

    assign o_data = chain_q[DEPTH-1];

endmodule

// File: rtl/uart_receive.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry output register.
// Optional input synchronizer: define UART_RECEIVE_SYNCHRONIZER_EN to pass
// i_rx through a 2-flop chain (adds 2 cycles of latency). Without it, i_rx
// is used directly and must be synchronous to i_clock.
module uart_receive
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQUENCY = 125_000_000,
    parameter int BAUD_RATE       = 115_200
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic                 o_framing_error,
    output logic                 o_overrun
);

    // N_CLOCKS must be at least 4 so that HALF-1 is a valid, distinct count.
    localparam int N_CLOCKS = clocks_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
    localparam int HALF     = N_CLOCKS / 2;
    localparam int N_WIDTH  = $clog2(N_CLOCKS);
    localparam int BIT_W    = $clog2(DATA_BITS);

    localparam logic [N_WIDTH-1:0] CNT_HALF = N_WIDTH'(HALF - 1);
    localparam logic [N_WIDTH-1:0] CNT_LAST = N_WIDTH'(N_CLOCKS - 1);
    localparam logic [N_WIDTH-1:0] CNT_ONE  = N_WIDTH'(1);
    localparam logic [BIT_W-1:0]   BIT_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]   BIT_ONE  = BIT_W'(1);

    logic rx_s;

`ifdef UART_RECEIVE_SYNCHRONIZER_EN
    uart_synchronizer #(
        .DEPTH       (2),
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_data  (i_rx),
        .o_data  (rx_s)
    );
`else
    assign rx_s = i_rx;
`endif

    rx_state_t            state_q;
    logic [N_WIDTH-1:0]   count_q;
    logic [BIT_W-1:0]     bit_q;
    logic [DATA_BITS-1:0] shift_q;

    // Bit-timing FSM: the counter restarts on every state change and after
    // every sample, so each sample lands at the middle of its bit period.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= IDLE;
            count_q <= '0;
            bit_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    count_q <= '0;
                    if (!rx_s) begin
                        state_q <= START;
                    end
                end
                START: begin
                    if (count_q == CNT_HALF) begin
                        count_q <= '0;
                        if (rx_s) begin
                            // Line went back high before mid-start: noise.
                            state_q <= IDLE;
                        end else begin
                            state_q <= DATA;
                            bit_q   <= '0;
                        end
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                DATA: begin
                    if (count_q == CNT_LAST) begin
                        count_q <= '0;
                        shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + BIT_ONE;
                        end
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (count_q == CNT_LAST) begin
                        // Rearm at mid-stop so a start bit right after the
                        // stop bit is not missed.
                        count_q <= '0;
                        state_q <= IDLE;
                    end else begin
                        count_q <= count_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    count_q <= '0;
                end
            endcase
        end
    end

    logic stop_sample;
    logic byte_done;
    logic frame_bad;

    assign stop_sample = (state_q == STOP) && (count_q == CNT_LAST);
    assign byte_done   = stop_sample && rx_s;
    assign frame_bad   = stop_sample && !rx_s;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    // Output register next state: a completed byte may replace a byte that is
    // being drained in the same cycle; otherwise a full register drops it.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = frame_bad;
        ovr_d   = 1'b0;
        if (byte_done) begin
            if (!valid_q || i_data_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_data_ready) begin
            valid_d = 1'b0;
        end
    end

    // Register the output byte, its valid flag, and the error pulses.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data          = data_q;
    assign o_data_valid    = valid_q;
    assign o_framing_error = ferr_q;
    assign o_overrun       = ovr_q;

endmodule

// File: tb/tb_uart_receive.sv
// Self-checking bench for uart_receive at 16 clocks per bit.
module tb_uart_receive;

    localparam int NCLK = 16;
`ifdef UART_RECEIVE_SYNCHRONIZER_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // Stop bit is sampled half a bit into the tenth bit period of the frame.
    localparam int LAT = 9 * NCLK + NCLK / 2 + SYNC_LAT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       ready = 1'b1;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_framing_error;
    logic       o_overrun;

    uart_receive #(
        .CLOCK_FREQUENCY (1_600_000),
        .BAUD_RATE       (100_000)
    ) dut (
        .i_clock         (clk),
        .i_reset         (rst),
        .i_rx            (rx),
        .o_data          (o_data),
        .o_data_valid    (o_data_valid),
        .i_data_ready    (ready),
        .o_framing_error (o_framing_error),
        .o_overrun       (o_overrun)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] exp_q[$];
    int         ferr_cnt = 0, ovr_cnt = 0, hs_cnt = 0, vhi_cnt = 0;
    int         e0_cyc = 0, rise_cyc = 0;
    logic       valid_prev = 1'b0;
    logic [7:0] data_prev = 8'h00;
    logic       rnd_done;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observe one cycle after each edge; a handshake at this edge used the
    // valid/data seen after the previous edge and the ready now on the pin.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (!rst) begin
            if (valid_prev && ready) begin
                hs_cnt++;
                chk("byte_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("rx_byte", data_prev, exp_q.pop_front());
            end
            if (o_framing_error) ferr_cnt++;
            if (o_overrun) ovr_cnt++;
            if (o_data_valid) vhi_cnt++;
            if (o_data_valid && !valid_prev) rise_cyc = cyc;
        end
        valid_prev = o_data_valid;
        data_prev  = o_data;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame starting at the current negedge; ends with the line high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        e0_cyc = cyc + 1;
        idle(NCLK);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            idle(NCLK);
        end
        rx = stop_bit;
        idle(NCLK);
        rx = 1'b1;
    endtask

    initial begin
        int f0, o0, v0, h0, exp_ferr;
        logic [7:0] b;
        logic good;

        idle(3);
        chk("rst_data", o_data, 8'h00);
        chk("rst_valid", o_data_valid, 1'b0);
        chk("rst_ferr", o_framing_error, 1'b0);
        chk("rst_ovr", o_overrun, 1'b0);
        rst = 1'b0;
        idle(5);

        // Single byte, ready high
        v0 = vhi_cnt;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1);
        idle(4);
        chk("a5_latency", rise_cyc - e0_cyc, LAT);
        chk("a5_valid_cycles", vhi_cnt - v0, 1);
        chk("a5_data_hold", o_data, 8'hA5);
        chk("a5_drained", exp_q.size(), 0);

        // Back-to-back frames
        f0 = ferr_cnt; o0 = ovr_cnt;
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); exp_q.push_back(8'h3C);
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(20);
        chk("b2b_drained", exp_q.size(), 0);
        chk("b2b_ferr", ferr_cnt - f0, 0);
        chk("b2b_ovr", ovr_cnt - o0, 0);

        // Framing error then a clean frame
        f0 = ferr_cnt; v0 = vhi_cnt;
        send_frame(8'h55, 1'b0);
        idle(32);
        chk("ferr_pulse", ferr_cnt - f0, 1);
        chk("ferr_no_valid", vhi_cnt - v0, 0);
        exp_q.push_back(8'h12);
        send_frame(8'h12, 1'b1);
        idle(20);
        chk("after_ferr_drained", exp_q.size(), 0);
        chk("after_ferr_count", ferr_cnt - f0, 1);

        // Short low glitch on an idle line
        f0 = ferr_cnt; o0 = ovr_cnt; v0 = vhi_cnt;
        rx = 1'b0;
        idle(4);
        rx = 1'b1;
        idle(200);
        chk("glitch_no_valid", vhi_cnt - v0, 0);
        chk("glitch_no_ferr", ferr_cnt - f0, 0);
        chk("glitch_no_ovr", ovr_cnt - o0, 0);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1);
        idle(20);
        chk("glitch_rearm_latency", rise_cyc - e0_cyc, LAT);
        chk("glitch_rearm_drained", exp_q.size(), 0);

        // Overrun with ready low
        o0 = ovr_cnt; h0 = hs_cnt;
        ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(10);
        chk("ovr_data_kept", o_data, 8'h11);
        chk("ovr_valid_held", o_data_valid, 1'b1);
        chk("ovr_pulse", ovr_cnt - o0, 1);
        chk("ovr_no_handshake", hs_cnt - h0, 0);
        ready = 1'b1;
        idle(5);
        chk("ovr_drain_one", hs_cnt - h0, 1);
        chk("ovr_valid_cleared", o_data_valid, 1'b0);
        chk("ovr_drained", exp_q.size(), 0);

        // Reset in the middle of the data bits
        f0 = ferr_cnt;
        rx = 1'b0; idle(NCLK);
        rx = 1'b1; idle(NCLK);
        rx = 1'b0; idle(NCLK / 2);
        rst = 1'b1;
        rx = 1'b1;
        idle(3);
        chk("midrst_data", o_data, 8'h00);
        chk("midrst_valid", o_data_valid, 1'b0);
        rst = 1'b0;
        idle(5);
        exp_q.push_back(8'h7E);
        send_frame(8'h7E, 1'b1);
        idle(20);
        chk("midrst_latency", rise_cyc - e0_cyc, LAT);
        chk("midrst_drained", exp_q.size(), 0);
        chk("midrst_no_ferr", ferr_cnt - f0, 0);

        // Randomized frames, random gaps, random stop bits, random ready
        f0 = ferr_cnt; o0 = ovr_cnt; exp_ferr = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int n = 0; n < 24; n++) begin
                    b = 8'($urandom);
                    good = ($urandom % 6) != 0;
                    if (good) exp_q.push_back(b);
                    else exp_ferr++;
                    send_frame(b, good);
                    idle(good ? int'($urandom % 6) : 4 + int'($urandom % 6));
                end
                idle(40);
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    ready = 1'($urandom % 2);
                    @(negedge clk);
                end
            end
        join
        ready = 1'b1;
        idle(5);
        chk("rand_drained", exp_q.size(), 0);
        chk("rand_ferr", ferr_cnt - f0, exp_ferr);
        chk("rand_no_ovr", ovr_cnt - o0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
